// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and FSM encoding for the MEM stage.
package mem_stage_pkg;

    typedef logic [1:0] memState_t;

    localparam memState_t IDLE   = 2'd0;
    localparam memState_t ACCESS = 2'd1;
    localparam memState_t DONE   = 2'd2;

    localparam int ADDR_BASE_DEF = 1024;
    localparam int AW_DEF        = 16;
    localparam int TIMEOUT_DEF   = 15;

endpackage

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: req/ack data-memory sequencer with timeout and read latch.
// Optional MEM_ALIGN_CHECK_EN rejects accesses with nonzero low address bits.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BASE      = ADDR_BASE_DEF,
    parameter int AW             = AW_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reIn,
    input  logic          weIn,
    input  logic [AW+1:0] addrIn,
    input  logic [31:0]   wData,
    input  logic [31:0]   memRData,
    input  logic          memAck,
    output memState_t     state,
    output logic          memReq,
    output logic          memWe,
    output logic [AW-1:0] memAddr,
    output logic [31:0]   memWData,
    output logic [31:0]   rdData,
    output logic          memErr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0]   BASE     = 32'(ADDR_BASE);
    localparam logic [AW-1:0] BASE_IDX = BASE[AW+1:2];
    localparam logic [1:0]    BASE_LO  = BASE[1:0];
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [AW-1:0] wordIdx;
    logic          misaligned;

    // Word-index form of (addr - base) >> 2; the borrow comes from the low bits.
    always_comb begin
        wordIdx = addrIn[AW+1:2] - BASE_IDX - AW'(addrIn[1:0] < BASE_LO);
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = addrIn[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            rdData   <= '0;
            memErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reIn | weIn) begin
                        if (misaligned) begin
                            memErr <= 1'b1;
                            rdData <= '0;
                            state  <= DONE;
                        end else begin
                            memReq   <= 1'b1;
                            memWe    <= weIn;
                            memAddr  <= wordIdx;
                            memWData <= wData;
                            cnt      <= '0;
                            state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        rdData <= memRData;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        memReq <= 1'b0;
                        memErr <= 1'b1;
                        rdData <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM pipeline stage with freeze generation and MEM/WB register.
// Build option MEM_ALIGN_CHECK_EN enables misaligned-access rejection.
module mem_stage_sram
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BASE      = ADDR_BASE_DEF,
    parameter int AW             = AW_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wbEnIn,
    input  logic          memREnIn,
    input  logic          memWEnIn,
    input  logic [31:0]   aluResIn,
    input  logic [31:0]   valRmIn,
    input  logic [3:0]    destIn,
    output logic          memReq,
    output logic          memWe,
    output logic [AW-1:0] memAddr,
    output logic [31:0]   memWData,
    input  logic [31:0]   memRData,
    input  logic          memAck,
    output logic          freeze,
    output logic          wbEnOut,
    output logic          memREnOut,
    output logic [31:0]   aluResOut,
    output logic [31:0]   memDataOut,
    output logic [3:0]    destOut,
    output logic          memErr
);

    memState_t   state;
    logic [31:0] rdData;
    logic        isLoad;

    // A load with the store enable also set is treated purely as a store.
    assign isLoad = memREnIn & ~memWEnIn;

    mem_access_fsm #(
        .ADDR_BASE      (ADDR_BASE),
        .AW             (AW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) uAccess (
        .clk      (clk),
        .rst      (rst),
        .reIn     (memREnIn),
        .weIn     (memWEnIn),
        .addrIn   (aluResIn[AW+1:0]),
        .wData    (valRmIn),
        .memRData (memRData),
        .memAck   (memAck),
        .state    (state),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWData (memWData),
        .rdData   (rdData),
        .memErr   (memErr)
    );

    assign freeze = ((state == IDLE) & (memREnIn | memWEnIn))
                  | (state == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbEnOut    <= 1'b0;
            memREnOut  <= 1'b0;
            aluResOut  <= '0;
            memDataOut <= '0;
            destOut    <= '0;
        end else if (freeze) begin
            wbEnOut   <= 1'b0;
            memREnOut <= 1'b0;
        end else begin
            wbEnOut   <= wbEnIn;
            memREnOut <= isLoad;
            aluResOut <= aluResIn;
            destOut   <= destIn;
            if (isLoad) begin
                memDataOut <= rdData;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: scoreboard bench for the MEM stage (requests and MEM/WB).
// Expectations follow the MEM_ALIGN_CHECK_EN setting of the build.
module tb_mem_stage_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbEnIn = 1'b0;
    logic        memREnIn = 1'b0;
    logic        memWEnIn = 1'b0;
    logic [31:0] aluResIn = '0;
    logic [31:0] valRmIn = '0;
    logic [3:0]  destIn = '0;
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData = '0;
    logic        memAck = 1'b0;
    logic        freeze;
    logic        wbEnOut;
    logic        memREnOut;
    logic [31:0] aluResOut;
    logic [31:0] memDataOut;
    logic [3:0]  destOut;
    logic        memErr;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } reqExp_t;

    typedef struct {
        logic [31:0] aluRes;
        logic [3:0]  dest;
        logic        memREn;
        logic [31:0] memData;
    } wbExp_t;

    reqExp_t reqQ[$];
    wbExp_t  wbQ[$];

    int checks = 0;
    int failures = 0;
    int freezeCycles = 0;
    int reqCycles = 0;
    logic prevReq = 1'b0;

    mem_stage_sram dut (
        .clk        (clk),
        .rst        (rst),
        .wbEnIn     (wbEnIn),
        .memREnIn   (memREnIn),
        .memWEnIn   (memWEnIn),
        .aluResIn   (aluResIn),
        .valRmIn    (valRmIn),
        .destIn     (destIn),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memAck     (memAck),
        .freeze     (freeze),
        .wbEnOut    (wbEnOut),
        .memREnOut  (memREnOut),
        .aluResOut  (aluResOut),
        .memDataOut (memDataOut),
        .destOut    (destOut),
        .memErr     (memErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations when the DUT presents a request or a write-back.
    always @(negedge clk) begin
        if (memReq && !prevReq) begin
            if (reqQ.size() == 0) begin
                chk("unexpected_req", 32'(memReq), 32'd0);
            end else begin
                reqExp_t e;
                e = reqQ.pop_front();
                chk("req_we", 32'(memWe), 32'(e.we));
                chk("req_addr", 32'(memAddr), 32'(e.addr));
                chk("req_wdata", memWData, e.wdata);
            end
        end
        prevReq = memReq;
        if (memReq) reqCycles++;
        if (freeze) freezeCycles++;
        if (wbEnOut) begin
            if (wbQ.size() == 0) begin
                chk("unexpected_wb", 32'(wbEnOut), 32'd0);
            end else begin
                wbExp_t w;
                w = wbQ.pop_front();
                chk("wb_alures", aluResOut, w.aluRes);
                chk("wb_dest", 32'(destOut), 32'(w.dest));
                chk("wb_memren", 32'(memREnOut), 32'(w.memREn));
                chk("wb_memdata", memDataOut, w.memData);
            end
        end
    end

    task automatic clearIn();
        wbEnIn = 1'b0;
        memREnIn = 1'b0;
        memWEnIn = 1'b0;
        aluResIn = '0;
        valRmIn = '0;
        destIn = '0;
    endtask

    task automatic aluOp(input logic [31:0] res, input logic [3:0] dst,
                         input logic [31:0] expData);
        wbQ.push_back('{res, dst, 1'b0, expData});
        freezeCycles = 0;
        wbEnIn = 1'b1;
        aluResIn = res;
        destIn = dst;
        @(posedge clk); #1;
        clearIn();
        @(posedge clk); #1;
        chk("alu_freeze", 32'(freezeCycles), 32'd0);
    endtask

    // nCyc ACCESS cycles; ack (if any) lands in the last one.
    task automatic memOp(input logic re, input logic we, input logic wbEn,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] dst, input int nCyc,
                         input logic ack, input logic [31:0] rdata);
        freezeCycles = 0;
        reqCycles = 0;
        wbEnIn = wbEn;
        memREnIn = re;
        memWEnIn = we;
        aluResIn = addr;
        valRmIn = data;
        destIn = dst;
        @(posedge clk); #1;
        for (int i = 1; i <= nCyc; i++) begin
            if (ack && i == nCyc) begin
                memAck = 1'b1;
                memRData = rdata;
            end
            @(posedge clk); #1;
            memAck = 1'b0;
        end
        @(posedge clk); #1;
        clearIn();
        @(posedge clk); #1;
        chk("op_freeze_cycles", 32'(freezeCycles), 32'(nCyc + 1));
        chk("op_req_cycles", 32'(reqCycles), 32'(nCyc));
    endtask

    initial begin
        clearIn();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", 32'(memReq), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_wben", 32'(wbEnOut), 32'd0);
        chk("rst_memerr", 32'(memErr), 32'd0);
        chk("rst_memdata", memDataOut, 32'd0);
        chk("rst_memaddr", 32'(memAddr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        aluOp(32'h55, 4'd3, 32'h0);

        reqQ.push_back('{1'b0, 16'd2, 32'h0});
        wbQ.push_back('{32'd1032, 4'd5, 1'b1, 32'hCAFEF00D});
        memOp(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd5, 3, 1'b1, 32'hCAFEF00D);

        reqQ.push_back('{1'b1, 16'd1, 32'h12345678});
        memOp(1'b0, 1'b1, 1'b0, 32'd1028, 32'h12345678, 4'd7, 1, 1'b1, 32'h0);
        chk("store_memerr", 32'(memErr), 32'd0);
        chk("store_keeps_memdata", memDataOut, 32'hCAFEF00D);

        reqQ.push_back('{1'b0, 16'hFF00, 32'h0});
        wbQ.push_back('{32'd0, 4'd1, 1'b1, 32'h0BADF00D});
        memOp(1'b1, 1'b0, 1'b1, 32'd0, 32'h0, 4'd1, 2, 1'b1, 32'h0BADF00D);

        memAck = 1'b1;
        memRData = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stray_ack_req", 32'(memReq), 32'd0);
        chk("stray_ack_freeze", 32'(freeze), 32'd0);
        @(posedge clk); #1;
        memAck = 1'b0;
        aluOp(32'h77, 4'd9, 32'h0BADF00D);

        reqQ.push_back('{1'b1, 16'd0, 32'hA5A5A5A5});
        wbQ.push_back('{32'd1024, 4'd4, 1'b0, 32'h0BADF00D});
        memOp(1'b1, 1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 4'd4, 2, 1'b1,
              32'hDEADBEEF);

`ifdef MEM_ALIGN_CHECK_EN
        wbQ.push_back('{32'd1025, 4'd8, 1'b1, 32'h0});
        memOp(1'b1, 1'b0, 1'b1, 32'd1025, 32'h0, 4'd8, 0, 1'b0, 32'h0);
        chk("misalign_memerr", 32'(memErr), 32'd1);
`else
        reqQ.push_back('{1'b0, 16'd0, 32'h0});
        wbQ.push_back('{32'd1025, 4'd8, 1'b1, 32'h13579BDF});
        memOp(1'b1, 1'b0, 1'b1, 32'd1025, 32'h0, 4'd8, 1, 1'b1, 32'h13579BDF);
        chk("misalign_memerr", 32'(memErr), 32'd0);
`endif

        reqQ.push_back('{1'b0, 16'd3, 32'h0});
        wbQ.push_back('{32'd1036, 4'd2, 1'b1, 32'h0});
        memOp(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0, 4'd2, 15, 1'b0, 32'h0);
        chk("timeout_memerr", 32'(memErr), 32'd1);
        aluOp(32'h99, 4'd6, 32'h0);
        chk("timeout_memerr_sticky", 32'(memErr), 32'd1);

        reqQ.push_back('{1'b0, 16'd4, 32'h0});
        wbEnIn = 1'b1;
        memREnIn = 1'b1;
        aluResIn = 32'd1040;
        destIn = 4'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clearIn();
        memAck = 1'b1;
        memRData = 32'h11111111;
        @(negedge clk);
        chk("rstmid_memreq", 32'(memReq), 32'd0);
        chk("rstmid_freeze", 32'(freeze), 32'd0);
        chk("rstmid_memerr", 32'(memErr), 32'd0);
        chk("rstmid_wben", 32'(wbEnOut), 32'd0);
        chk("rstmid_memaddr", 32'(memAddr), 32'd0);
        chk("rstmid_alures", aluResOut, 32'd0);
        @(posedge clk); #1;
        memAck = 1'b0;
        @(negedge clk);
        chk("rstmid_state", 32'(dut.uAccess.state), 32'd0);
        chk("rstmid_ack_ignored_req", 32'(memReq), 32'd0);
        chk("rstmid_ack_ignored_data", memDataOut, 32'd0);
        @(posedge clk); #1;

        aluOp(32'h1234, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        chk("req_queue_empty", 32'(reqQ.size()), 32'd0);
        chk("wb_queue_empty", 32'(wbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
